mdu_iterative: RTL and testbench
================================

Name: mdu_iterative

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, alongside the ALU.
- Executes instructions with opcode OP and F7 = 0000001; F3 selects the operation.
- Produces one result per operation through a start/busy/done handshake.
- The hazard unit stalls the pipeline while busy is high.

Parameters:
- XLEN, 32, operand and result width; the iteration count equals XLEN.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-low reset: sampled on the rising edge of clk, active when 0.
- start  input  1  request; sampled only in IDLE or DONE.
- F3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1  input  XLEN  operand A (dividend / multiplicand).
- rs2  input  XLEN  operand B (divisor / multiplier).
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; result is valid in this cycle.
- result  output  XLEN  registered result; held until the next accepted start.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, busy=0, done=0, result=0, counter=0, all internal registers=0.
- Reset mid-operation aborts immediately with the same values; no done pulse is produced.
- States: IDLE, RUN, DONE.
- Accept rule: start=1 at edge k while state is IDLE or DONE.
  - Latch F3, rs1 and rs2.
  - Compute sign flags and absolute values.
  - Load counter=XLEN.
- Accept-edge handling for non-special ops:
  - Go to RUN; busy=1 from cycle k+1.
- Accept-edge handling for special cases (no RUN state; go directly to DONE at k+1, busy stays 0):
  - DIV/DIVU with rs2=0: quotient = all ones; REM/REMU result = rs1.
  - DIV with rs1=0x80000000, rs2=0xFFFFFFFF: quotient = 0x80000000; REM result = 0.
- RUN, multiply (shift-add over an unsigned 2*XLEN accumulator):
  - Each cycle: if the multiplier LSB is 1, add the multiplicand to the upper half; then shift the accumulator right by 1.
  - Counter decrements; when it reaches 1, the next state is DONE.
  - Done is asserted at cycle k+XLEN+1.
- RUN, divide (restoring division over unsigned magnitudes):
  - Each cycle: shift {rem,quot} left by 1, trial-subtract the divisor, set the quotient LSB if the result is non-negative.
  - Same counter and latency as multiply.
- Signedness:
  - MUL, MULH, DIV and REM treat both operands as signed.
  - MULHSU treats rs1 as signed and rs2 as unsigned.
  - MULHU, DIVU and REMU treat both as unsigned.
- Sign fixup, applied on entry to DONE:
  - Product negated if sign(A) xor sign(B), after the signedness rules above.
  - Quotient negated if sA xor sB.
  - Remainder takes the sign of the dividend.
- Result selection:
  - MUL returns the low XLEN bits of the product; MULH, MULHSU and MULHU return the high XLEN bits.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- DONE:
  - done=1 and busy=0 for exactly one cycle; result is registered on the DONE-entry edge.
  - Next state is IDLE, or RUN/DONE if start=1 (back-to-back accept allowed).
- start during RUN is ignored; no queueing, and the latched operands are unaffected.
- Operand or F3 changes after the accept edge have no effect.
- result is stable from the DONE-entry edge until the edge after the next accept.
- busy and done are never high in the same cycle.

Test Plan:
- Reset: rst=0 for 2 cycles during a RUN → busy=0, done=0, result=0; no done pulse afterwards; a fresh start works normally.
- MUL: rs1=7, rs2=-3 (0xFFFFFFFD), F3=000 → done at k+33, result=0xFFFFFFEB; MULH on the same operands → 0xFFFFFFFF; MULHU on the same operands → 0x00000006.
- DIV/REM with signed operands:
  - DIV: rs1=-20, rs2=6 → quotient 0xFFFFFFFD (-3).
  - REM: rs1=-20, rs2=6 → 0xFFFFFFFE (-2).
  - Both complete in 33 cycles.
- Divide by zero: DIVU rs1=0x1234, rs2=0 → done at k+1, result=0xFFFFFFFF, busy never asserted; REMU on the same operands → 0x1234.
- Overflow: DIV rs1=0x80000000, rs2=0xFFFFFFFF → 0x80000000 at k+1; REM on the same operands → 0.
- Handshake:
  - start held high during RUN → ignored, exactly one done.
  - start=1 in the DONE cycle with MULHSU rs1=-1, rs2=2 → accepted; the new result is 0xFFFFFFFF; the previous result is held until then.

Source files
------------

// File: rtl/mdu_iterative_if.sv
// Request/response bundle between the execute stage and the iterative multiply/divide unit.
interface mdu_iterative_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      F3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, F3, rs1, rs2,
        input  busy, done, result
    );

    modport slave (
        input  start, F3, rs1, rs2,
        output busy, done, result
    );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on magnitudes,
// one bit per cycle, with sign fixup applied on the edge that enters DONE.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one multiply/divide iteration per cycle, busy high
// DONE  | one-cycle done pulse, result valid; a new start may be accepted
module mdu_iterative #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    mdu_iterative_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [2:0]      op;
    logic            neg_res, neg_rem;
    logic [CNT_W-1:0] counter;
    logic [XLEN-1:0] hi, lo, opb;
    logic [XLEN-1:0] result;

    logic            accept, sa, sb, div_zero, div_ovf, special;
    logic [XLEN-1:0] abs_a, abs_b, special_res;
    logic [XLEN:0]   mul_sum, rem_sh, div_diff;
    logic [XLEN-1:0] hi_nxt, lo_nxt, final_res;
    logic [2*XLEN-1:0] prod, prod_f;
    logic [XLEN-1:0] quot_f, rem_f;

    assign accept = bus.start && (state != RUN);

    // Operand signedness per F3: rs1 signed for all but MULHU/DIVU/REMU, rs2 also unsigned for MULHSU.
    assign sa = bus.rs1[XLEN-1] && (bus.F3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110});
    assign sb = bus.rs2[XLEN-1] && (bus.F3 inside {3'b000, 3'b001, 3'b100, 3'b110});
    assign abs_a = sa ? -bus.rs1 : bus.rs1;
    assign abs_b = sb ? -bus.rs2 : bus.rs2;

    assign div_zero = bus.F3[2] && (bus.rs2 == '0);
    assign div_ovf  = (bus.F3 == 3'b100 || bus.F3 == 3'b110)
                      && (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2 == '1);
    assign special  = div_zero || div_ovf;

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = bus.F3[1] ? bus.rs1 : '1;
        else if (div_ovf)
            special_res = bus.F3[1] ? '0 : bus.rs1;
    end

    // hi holds the product upper half / partial remainder, lo the multiplier / quotient.
    assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    assign rem_sh   = {hi, lo[XLEN-1]};
    assign div_diff = rem_sh - {1'b0, opb};

    always_comb begin
        hi_nxt = mul_sum[XLEN:1];
        lo_nxt = {mul_sum[0], lo[XLEN-1:1]};
        if (op[2]) begin
            if (!div_diff[XLEN]) begin
                hi_nxt = div_diff[XLEN-1:0];
                lo_nxt = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_nxt = rem_sh[XLEN-1:0];
                lo_nxt = {lo[XLEN-2:0], 1'b0};
            end
        end
    end

    assign prod   = {hi_nxt, lo_nxt};
    assign prod_f = neg_res ? -prod : prod;
    assign quot_f = neg_res ? -lo_nxt : lo_nxt;
    assign rem_f  = neg_rem ? -hi_nxt : hi_nxt;

    always_comb begin
        final_res = '0;
        case (op)
            3'b000:                 final_res = prod_f[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_f[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = quot_f;
            default:                final_res = rem_f;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (bus.start)
                    state_nxt = special ? DONE : RUN;
                else
                    state_nxt = IDLE;
            end
            RUN: begin
                if (counter == CNT_W'(1))
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            op      <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            counter <= '0;
            hi      <= '0;
            lo      <= '0;
            opb     <= '0;
            result  <= '0;
        end else if (accept) begin
            op      <= bus.F3;
            neg_res <= sa ^ sb;
            neg_rem <= sa;
            counter <= CNT_W'(XLEN);
            hi      <= '0;
            lo      <= bus.F3[2] ? abs_a : abs_b;
            opb     <= bus.F3[2] ? abs_b : abs_a;
            if (special)
                result <= special_res;
        end else if (state == RUN) begin
            hi      <= hi_nxt;
            lo      <= lo_nxt;
            counter <= counter - CNT_W'(1);
            if (counter == CNT_W'(1))
                result <= final_res;
        end
    end

    assign bus.busy   = (state == RUN);
    assign bus.done   = (state == DONE);
    assign bus.result = result;
endmodule

// File: tb/tb_mdu_iterative.sv
// Directed bench for mdu_iterative: reset, multiply/divide results, special cases and handshake.
module tb_mdu_iterative;
    logic clk;
    logic rst;
    int   nrun;
    int   nfail;

    mdu_iterative_if #(.XLEN(32)) bus ();

    mdu_iterative #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a request so it is sampled on the next rising edge, then scramble the inputs.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.F3    = f3;
        bus.rs1   = a;
        bus.rs2   = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.F3    = ~f3;
        bus.rs1   = ~a;
        bus.rs2   = b + 32'd1;
    endtask

    // lat = 1 in the cycle right after the accept edge.
    task automatic wait_done(output int lat, output logic [31:0] res, output logic saw_busy,
                             output logic overlap);
        lat      = 1;
        res      = 32'hDEAD_DEAD;
        saw_busy = 1'b0;
        overlap  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.busy && bus.done) overlap = 1'b1;
            if (bus.busy) saw_busy = 1'b1;
            if (bus.done) begin
                res = bus.result;
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        int          lat, ndone;
        logic [31:0] res;
        logic        sb, ov;
        rst = 1'b0;
        bus.start = 1'b0; bus.F3 = '0; bus.rs1 = '0; bus.rs2 = '0;
        repeat (3) @(posedge clk);
        #1;
        nrun++;
        if ({bus.busy, bus.done, bus.result} !== 34'd0) begin
            nfail++;
            $display("FAIL reset_idle: busy=%b done=%b result=%h, want 0 0 0", bus.busy, bus.done, bus.result);
        end
        rst = 1'b1;
        issue(3'b101, 32'h1234, 32'h0);
        wait_done(lat, res, sb, ov);
        issue(3'b000, 32'd7, 32'hFFFF_FFFD);
        repeat (10) @(posedge clk);
        #1;
        nrun++;
        if (bus.busy !== 1'b1) begin
            nfail++;
            $display("FAIL reset_prebusy: busy=%b, want 1", bus.busy);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nrun++;
        if ({bus.busy, bus.done, bus.result} !== 34'd0) begin
            nfail++;
            $display("FAIL reset_midrun: busy=%b done=%b result=%h, want 0 0 0", bus.busy, bus.done, bus.result);
        end
        rst = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) ndone++;
        end
        nrun++;
        if (ndone !== 0) begin
            nfail++;
            $display("FAIL reset_nodone: %0d busy/done cycles after reset, want 0", ndone);
        end
        issue(3'b000, 32'd7, 32'hFFFF_FFFD);
        wait_done(lat, res, sb, ov);
        nrun++;
        if (res !== 32'hFFFF_FFEB || lat !== 33) begin
            nfail++;
            $display("FAIL reset_fresh: result=%h lat=%0d, want ffffffeb 33", res, lat);
        end
    endtask

    task automatic test_mul();
        logic [2:0]  f3s [3] = '{3'b000, 3'b001, 3'b011};
        logic [31:0] exps[3] = '{32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'h0000_0006};
        int          lat;
        logic [31:0] res;
        logic        sb, ov;
        for (int i = 0; i < 3; i++) begin
            issue(f3s[i], 32'd7, 32'hFFFF_FFFD);
            wait_done(lat, res, sb, ov);
            nrun++;
            if (res !== exps[i] || lat !== 33 || sb !== 1'b1 || ov !== 1'b0) begin
                nfail++;
                $display("FAIL mul_f3_%b: result=%h lat=%0d busy=%b overlap=%b, want %h 33 1 0",
                         f3s[i], res, lat, sb, ov, exps[i]);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  f3s [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] as  [4] = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd100, 32'd100};
        logic [31:0] bs  [4] = '{32'd6, 32'd6, 32'd7, 32'd7};
        logic [31:0] exps[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd14, 32'd2};
        int          lat;
        logic [31:0] res;
        logic        sb, ov;
        for (int i = 0; i < 4; i++) begin
            issue(f3s[i], as[i], bs[i]);
            wait_done(lat, res, sb, ov);
            nrun++;
            if (res !== exps[i] || lat !== 33 || sb !== 1'b1 || ov !== 1'b0) begin
                nfail++;
                $display("FAIL div_f3_%b: result=%h lat=%0d busy=%b overlap=%b, want %h 33 1 0",
                         f3s[i], res, lat, sb, ov, exps[i]);
            end
        end
    endtask

    task automatic test_special();
        logic [2:0]  f3s [6] = '{3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110};
        logic [31:0] as  [6] = '{32'h1234, 32'h1234, 32'hFFFF_FFFB, 32'hFFFF_FFFB,
                                 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exps[6] = '{32'hFFFF_FFFF, 32'h1234, 32'hFFFF_FFFF, 32'hFFFF_FFFB,
                                 32'h8000_0000, 32'h0};
        int          lat;
        logic [31:0] res;
        logic        sb, ov;
        for (int i = 0; i < 6; i++) begin
            issue(f3s[i], as[i], bs[i]);
            wait_done(lat, res, sb, ov);
            nrun++;
            if (res !== exps[i] || lat !== 1 || sb !== 1'b0) begin
                nfail++;
                $display("FAIL special_%0d: result=%h lat=%0d busy=%b, want %h 1 0",
                         i, res, lat, sb, exps[i]);
            end
        end
    endtask

    task automatic test_start_held();
        int          lat, extra;
        logic [31:0] res;
        @(negedge clk);
        bus.start = 1'b1; bus.F3 = 3'b000; bus.rs1 = 32'd5; bus.rs2 = 32'd6;
        @(posedge clk);
        #1;
        bus.rs1 = 32'd9; bus.rs2 = 32'd9; bus.F3 = 3'b011;
        lat = 1;
        res = 32'hDEAD_DEAD;
        for (int i = 0; i < 100; i++) begin
            if (bus.done) begin
                res = bus.result;
                bus.start = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        bus.start = 1'b0;
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) extra++;
        end
        nrun++;
        if (res !== 32'd30 || lat !== 33 || extra !== 0) begin
            nfail++;
            $display("FAIL start_held: result=%h lat=%0d extra_done=%0d, want 0000001e 33 0", res, lat, extra);
        end
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic [31:0] res;
        logic        sb, ov;
        issue(3'b000, 32'd7, 32'hFFFF_FFFD);
        wait_done(lat, res, sb, ov);
        bus.start = 1'b1; bus.F3 = 3'b010; bus.rs1 = 32'hFFFF_FFFF; bus.rs2 = 32'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.F3 = 3'b000; bus.rs1 = 32'd3; bus.rs2 = 32'd3;
        nrun++;
        if (bus.busy !== 1'b1 || bus.result !== 32'hFFFF_FFEB) begin
            nfail++;
            $display("FAIL b2b_accept: busy=%b result=%h, want 1 ffffffeb", bus.busy, bus.result);
        end
        repeat (5) @(posedge clk);
        #1;
        nrun++;
        if (bus.result !== 32'hFFFF_FFEB) begin
            nfail++;
            $display("FAIL b2b_hold: result=%h, want ffffffeb", bus.result);
        end
        wait_done(lat, res, sb, ov);
        nrun++;
        if (res !== 32'hFFFF_FFFF || lat !== 28 || ov !== 1'b0) begin
            nfail++;
            $display("FAIL b2b_mulhsu: result=%h lat=%0d overlap=%b, want ffffffff 28 0", res, lat, ov);
        end
    endtask

    initial begin
        nrun  = 0;
        nfail = 0;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_start_held();
        test_back_to_back();
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", nrun, nfail);
        $finish;
    end
endmodule
